// File: rtl/bp_cfg_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_cfg_loader_pkg                                             |
// | Description : Shared types and constants for the runtime config loader:     |
// |               FSM state encoding, default geometry and named field indices. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package bp_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_load   = 3'd1,
    e_edit   = 3'd2,
    e_active = 3'd3,
    e_locked = 3'd4
  } bp_cfg_loader_state_e;

  // Default geometry of the config table
  localparam int BP_CFG_NUM_CFGS    = 11;
  localparam int BP_CFG_NUM_FIELDS  = 16;
  localparam int BP_CFG_FIELD_WIDTH = 16;

  // Field positions inside one config image, as seen by the tile consumers
  localparam int BP_CFG_F_CORE_ID    = 0;
  localparam int BP_CFG_F_CACHE_SETS = 1;
  localparam int BP_CFG_F_CACHE_WAYS = 2;
  localparam int BP_CFG_F_TLB_ENTS   = 3;
  localparam int BP_CFG_F_BTB_ENTS   = 4;
  localparam int BP_CFG_F_FEATURES   = 5;

endpackage
`default_nettype wire

// File: rtl/bp_cfg_loader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_cfg_loader_rom                                             |
// | Description : Combinational lookup of one field of one base config out of   |
// |               the flat parameter ROM. Out-of-range selects return zero.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bp_cfg_loader_rom
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_cfgs_p    = BP_CFG_NUM_CFGS,
  parameter int num_fields_p  = BP_CFG_NUM_FIELDS,
  parameter int field_width_p = BP_CFG_FIELD_WIDTH,
  parameter int sel_width_p   = 4,
  parameter int idx_width_p   = 4,
  parameter logic [num_cfgs_p*num_fields_p*field_width_p-1:0] base_cfgs_p = '0
) (
  input  logic [sel_width_p-1:0]   sel,
  input  logic [idx_width_p-1:0]   field,
  output logic [field_width_p-1:0] data
);

  localparam int entries_lp = num_cfgs_p * num_fields_p;
  localparam int flat_w_lp  = (entries_lp > 1) ? $clog2(entries_lp) : 1;

  logic [field_width_p-1:0] table_mem [entries_lp];
  logic [flat_w_lp-1:0]     flat_idx;
  logic                     in_range;

  // Unflatten the ROM parameter into one word per (config, field)
  for (genvar e = 0; e < entries_lp; e++) begin : g_table
    assign table_mem[e] = base_cfgs_p[e*field_width_p +: field_width_p];
  end

  assign flat_idx = flat_w_lp'(sel) * flat_w_lp'(num_fields_p) + flat_w_lp'(field);
  assign in_range = ({1'b0, sel}   < (sel_width_p + 1)'(num_cfgs_p)) &&
                    ({1'b0, field} < (idx_width_p + 1)'(num_fields_p));
  assign data     = in_range ? table_mem[flat_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/bp_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_cfg_loader                                                 |
// | Description : Loads a base config from ROM into a shadow register file one  |
// |               field per cycle, lets software patch fields, publishes the    |
// |               image on cfg_o and finally locks it until reset.              |
// |               Optional macro BP_CFG_LOADER_PARITY_EN adds an even-parity    |
// |               bit per shadow field that is checked at commit time.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_cfgs_p    = BP_CFG_NUM_CFGS,
  parameter int num_fields_p  = BP_CFG_NUM_FIELDS,
  parameter int field_width_p = BP_CFG_FIELD_WIDTH,
  parameter logic [num_cfgs_p*num_fields_p*field_width_p-1:0] base_cfgs_p = '0,
  localparam int sel_width_lp  = (num_cfgs_p > 1) ? $clog2(num_cfgs_p) : 1,
  // One extra bit so indexes at and beyond num_fields_p can be presented and rejected
  localparam int addr_width_lp = $clog2(num_fields_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  load_v_i,
  input  logic [sel_width_lp-1:0]               cfg_sel_i,
  input  logic                                  w_v_i,
  output logic                                  w_ready_o,
  input  logic [addr_width_lp-1:0]              w_addr_i,
  input  logic [field_width_p-1:0]              w_data_i,
  input  logic                                  commit_i,
  input  logic                                  lock_i,
  input  logic [addr_width_lp-1:0]              r_addr_i,
  output logic [field_width_p-1:0]              r_data_o,
  output logic [num_fields_p*field_width_p-1:0] cfg_o,
  output logic                                  cfg_v_o,
  output logic                                  busy_o,
  output logic                                  locked_o,
  output logic                                  error_o
);

  localparam int idx_width_lp = (num_fields_p > 1) ? $clog2(num_fields_p) : 1;
  localparam logic [addr_width_lp-1:0] num_fields_lp  = addr_width_lp'(num_fields_p);
  localparam logic [sel_width_lp:0]    num_cfgs_lp    = (sel_width_lp + 1)'(num_cfgs_p);
  localparam logic [idx_width_lp-1:0]  last_field_lp  = idx_width_lp'(num_fields_p - 1);

  bp_cfg_loader_state_e state_q;

  logic [sel_width_lp-1:0]               sel_q;
  logic [idx_width_lp-1:0]               cnt_q;
  logic [field_width_p-1:0]              shadow_q  [num_fields_p];
  logic [field_width_p-1:0]              shadow_wr [num_fields_p];
  logic [field_width_p-1:0]              rom_field;
  logic [num_fields_p*field_width_p-1:0] image_wr;
  logic [idx_width_lp-1:0]               w_idx;
  logic [idx_width_lp-1:0]               r_idx;
  logic                                  sel_ok;
  logic                                  w_fire;
  logic                                  w_addr_ok;
  logic                                  commit_ok;
  logic                                  start_load;

  bp_cfg_loader_rom #(
    .num_cfgs_p   (num_cfgs_p),
    .num_fields_p (num_fields_p),
    .field_width_p(field_width_p),
    .sel_width_p  (sel_width_lp),
    .idx_width_p  (idx_width_lp),
    .base_cfgs_p  (base_cfgs_p)
  ) rom (
    .sel  (sel_q),
    .field(cnt_q),
    .data (rom_field)
  );

  assign sel_ok    = (cfg_sel_i != '0) && ({1'b0, cfg_sel_i} < num_cfgs_lp);
  assign w_fire    = w_v_i & w_ready_o;
  assign w_addr_ok = (w_addr_i < num_fields_lp);
  assign w_idx     = w_addr_i[idx_width_lp-1:0];
  assign r_idx     = r_addr_i[idx_width_lp-1:0];

  // A valid load wins over everything except a lock request in e_active
  assign start_load = load_v_i && sel_ok &&
                      ((state_q == e_idle) || (state_q == e_edit) ||
                       ((state_q == e_active) && !lock_i));

  // Shadow contents as they will be after this cycle's accepted write, so a
  // commit in the same cycle publishes the patched value
  always_comb begin
    for (int f = 0; f < num_fields_p; f++) shadow_wr[f] = shadow_q[f];
    if (w_fire && w_addr_ok) shadow_wr[w_idx] = w_data_i;
  end

  for (genvar f = 0; f < num_fields_p; f++) begin : g_image
    assign image_wr[f*field_width_p +: field_width_p] = shadow_wr[f];
  end

  assign r_data_o = (r_addr_i < num_fields_lp) ? shadow_q[r_idx] : '0;

`ifdef BP_CFG_LOADER_PARITY_EN
  logic [num_fields_p-1:0] par_q;
  logic [num_fields_p-1:0] par_wr;

  // Parity image with this cycle's write merged, and the commit-time check
  always_comb begin
    par_wr = par_q;
    if (w_fire && w_addr_ok) par_wr[w_idx] = ^w_data_i;
    commit_ok = 1'b1;
    for (int f = 0; f < num_fields_p; f++) begin
      if ((^shadow_wr[f]) != par_wr[f]) commit_ok = 1'b0;
    end
  end

  // Parity bits follow the shadow: filled during load, updated by edits
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      par_q <= '0;
    end else if (state_q == e_load) begin
      par_q[cnt_q] <= ^rom_field;
    end else if ((state_q == e_edit) && !load_v_i) begin
      par_q <= par_wr;
    end
  end
`else
  assign commit_ok = 1'b1;
`endif

  // Control FSM with registered status outputs, shadow file and committed image
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      sel_q     <= '0;
      cnt_q     <= '0;
      for (int f = 0; f < num_fields_p; f++) shadow_q[f] <= '0;
      cfg_o     <= '0;
      cfg_v_o   <= 1'b0;
      w_ready_o <= 1'b0;
      busy_o    <= 1'b0;
      locked_o  <= 1'b0;
      error_o   <= 1'b0;
    end else if (start_load) begin
      state_q   <= e_load;
      sel_q     <= cfg_sel_i;
      cnt_q     <= '0;
      busy_o    <= 1'b1;
      w_ready_o <= 1'b0;
      error_o   <= 1'b0;
      cfg_v_o   <= 1'b0;
    end else begin
      case (state_q)
        e_idle: begin
          // Only an invalid select reaches here with load_v_i set
          if (load_v_i) error_o <= 1'b1;
        end
        e_load: begin
          shadow_q[cnt_q] <= rom_field;
          if (cnt_q == last_field_lp) begin
            state_q   <= e_edit;
            busy_o    <= 1'b0;
            w_ready_o <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + idx_width_lp'(1);
          end
        end
        e_edit: begin
          if (load_v_i) begin
            // Rejected load still pre-empts commit and write this cycle
            error_o <= 1'b1;
          end else begin
            if (w_fire && !w_addr_ok) error_o <= 1'b1;
            for (int f = 0; f < num_fields_p; f++) shadow_q[f] <= shadow_wr[f];
            if (commit_i) begin
              if (commit_ok) begin
                cfg_o     <= image_wr;
                cfg_v_o   <= 1'b1;
                w_ready_o <= 1'b0;
                state_q   <= e_active;
              end else begin
                error_o <= 1'b1;
              end
            end
          end
        end
        e_active: begin
          if (lock_i) begin
            state_q  <= e_locked;
            locked_o <= 1'b1;
            cfg_v_o  <= 1'b1;
          end else if (load_v_i) begin
            error_o <= 1'b1;
          end
        end
        e_locked: begin
          locked_o <= 1'b1;
        end
        default: begin
          state_q <= e_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_cfg_loader                                              |
// | Description : Self-checking bench for bp_cfg_loader. Keeps an abstract      |
// |               model of the shadow fields and committed image and drives     |
// |               randomized loads, edits, commits, locks and resets.           |
// |               Parity scenario compiled with BP_CFG_LOADER_PARITY_EN.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bp_cfg_loader;

  localparam int NC = 11;
  localparam int NF = 16;
  localparam int FW = 16;

  function automatic logic [FW-1:0] rom_word(input int k, input int f);
    return FW'((k * 32'h1357) ^ (f * 32'h0F1D) ^ ((k + f) << 8) ^ 32'h00A5);
  endfunction

  function automatic logic [NC*NF*FW-1:0] make_rom();
    logic [NC*NF*FW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      for (int f = 0; f < NF; f++)
        r[(k*NF+f)*FW +: FW] = rom_word(k, f);
    return r;
  endfunction

  localparam logic [NC*NF*FW-1:0] ROM = make_rom();

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_v = 1'b0;
  logic [3:0]       cfg_sel = '0;
  logic             w_v = 1'b0;
  logic             w_ready;
  logic [4:0]       w_addr = '0;
  logic [FW-1:0]    w_data = '0;
  logic             commit = 1'b0;
  logic             lock = 1'b0;
  logic [4:0]       r_addr = '0;
  logic [FW-1:0]    r_data;
  logic [NF*FW-1:0] cfg;
  logic             cfg_v;
  logic             busy;
  logic             locked;
  logic             err;

  // Reference model: shadow fields, committed image, committed-valid flag
  logic [FW-1:0] ms [NF];
  logic [FW-1:0] mc [NF];
  logic          model_cfg_v;

  int checks = 0;
  int errors = 0;

  bp_cfg_loader #(
    .num_cfgs_p   (NC),
    .num_fields_p (NF),
    .field_width_p(FW),
    .base_cfgs_p  (ROM)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_v_i (load_v),
    .cfg_sel_i(cfg_sel),
    .w_v_i    (w_v),
    .w_ready_o(w_ready),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .commit_i (commit),
    .lock_i   (lock),
    .r_addr_i (r_addr),
    .r_data_o (r_data),
    .cfg_o    (cfg),
    .cfg_v_o  (cfg_v),
    .busy_o   (busy),
    .locked_o (locked),
    .error_o  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1);
  end

  function automatic logic [NF*FW-1:0] pack_model();
    logic [NF*FW-1:0] v;
    for (int f = 0; f < NF; f++) v[f*FW +: FW] = mc[f];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int f = 0; f < NF; f++) begin
      ms[f] = '0;
      mc[f] = '0;
    end
    model_cfg_v = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_model();
  endtask

  // Reads every shadow field plus one out-of-range index; realigns to edge+1
  task automatic check_shadow(input string name);
    int bad;
    int first_f;
    logic [FW-1:0] got;
    logic [FW-1:0] expv;
    bad = 0;
    first_f = -1;
    got = '0;
    expv = '0;
    for (int f = 0; f < NF; f++) begin
      r_addr = 5'(f);
      #1;
      if (r_data !== ms[f]) begin
        if (bad == 0) begin
          first_f = f;
          got = r_data;
          expv = ms[f];
        end
        bad++;
      end
    end
    r_addr = 5'($urandom_range(NF, 31));
    #1;
    if (r_data !== '0) begin
      if (bad == 0) begin
        first_f = int'(r_addr);
        got = r_data;
        expv = '0;
      end
      bad++;
    end
    r_addr = '0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s shadow: %0d bad, index %0d got %h expected %h", name, bad, first_f, got, expv);
    end
    tick();
  endtask

  task automatic do_load(input int sel, input bit from_idle, input string name);
    int n;
    load_v = 1'b1;
    cfg_sel = 4'(sel);
    tick();
    load_v = 1'b0;
    cfg_sel = '0;
    model_cfg_v = 1'b0;
    checks++;
    if ({busy, w_ready, cfg_v} !== 3'b100) begin
      errors++;
      $display("FAIL %s start: busy/w_ready/cfg_v got %b expected 100", name, {busy, w_ready, cfg_v});
    end
    if (from_idle) begin
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL %s error_clear: got %b expected 0", name, err);
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != NF) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, NF);
    end
    checks++;
    if ({busy, w_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s edit_entry: busy/w_ready got %b expected 01", name, {busy, w_ready});
    end
    checks++;
    if (cfg !== pack_model()) begin
      errors++;
      $display("FAIL %s cfg_hold: got %h expected %h", name, cfg, pack_model());
    end
    for (int f = 0; f < NF; f++) ms[f] = rom_word(sel, f);
    check_shadow(name);
  endtask

  task automatic do_write(input int addr, input logic [FW-1:0] data, input bit with_commit);
    w_v = 1'b1;
    w_addr = 5'(addr);
    w_data = data;
    commit = with_commit;
    tick();
    w_v = 1'b0;
    commit = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (addr < NF) ms[addr] = data;
  endtask

  // Commit with a concurrent random in-range write, then compare the image
  task automatic commit_and_check(input string name);
    int a;
    logic [FW-1:0] d;
    a = int'($urandom_range(0, NF-1));
    d = FW'($urandom);
    w_v = 1'b1;
    w_addr = 5'(a);
    w_data = d;
    commit = 1'b1;
    #1;
    checks++;
    if (cfg_v !== 1'b0) begin
      errors++;
      $display("FAIL %s cfg_v_early: got %b expected 0", name, cfg_v);
    end
    tick();
    w_v = 1'b0;
    commit = 1'b0;
    ms[a] = d;
    for (int f = 0; f < NF; f++) mc[f] = ms[f];
    model_cfg_v = 1'b1;
    checks++;
    if ({cfg_v, w_ready} !== 2'b10 || cfg !== pack_model()) begin
      errors++;
      $display("FAIL %s commit: cfg_v/w_ready got %b cfg %h expected 10 cfg %h", name, {cfg_v, w_ready}, cfg, pack_model());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({cfg_v, w_ready, busy, locked, err} !== 5'b0 || cfg !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags %b cfg %h expected 00000 and 0", {cfg_v, w_ready, busy, locked, err}, cfg);
    end
    clear_model();
    check_shadow("reset");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    do_load(3, 1'b1, "load_sel3");
  endtask

  task automatic test_edit_commit();
    for (int i = 0; i < 3; i++) do_write(int'($urandom_range(0, NF-1)), FW'($urandom), 1'b0);
    check_shadow("edit_writes");
    lock = 1'b1;
    tick();
    lock = 1'b0;
    checks++;
    if ({locked, w_ready, cfg_v} !== 3'b010) begin
      errors++;
      $display("FAIL lock_in_edit: locked/w_ready/cfg_v got %b expected 010", {locked, w_ready, cfg_v});
    end
    w_v = 1'b1;
    w_addr = 5'd5;
    w_data = 16'hBEEF;
    commit = 1'b1;
    #1;
    checks++;
    if (cfg_v !== 1'b0) begin
      errors++;
      $display("FAIL beef_cfg_v_early: got %b expected 0", cfg_v);
    end
    tick();
    w_v = 1'b0;
    commit = 1'b0;
    ms[5] = 16'hBEEF;
    for (int f = 0; f < NF; f++) mc[f] = ms[f];
    model_cfg_v = 1'b1;
    checks++;
    if (cfg_v !== 1'b1 || cfg[5*FW +: FW] !== 16'hBEEF || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL beef_commit: cfg_v %b f5 %h w_ready %b expected 1 BEEF 0", cfg_v, cfg[5*FW +: FW], w_ready);
    end
    checks++;
    if (cfg !== pack_model()) begin
      errors++;
      $display("FAIL beef_image: got %h expected %h", cfg, pack_model());
    end
  endtask

  task automatic test_reload_active();
    do_load(int'($urandom_range(1, NC-1)), 1'b0, "reload_active");
    commit_and_check("reload_commit");
  endtask

  task automatic test_lock();
    lock = 1'b1;
    load_v = 1'b1;
    cfg_sel = 4'($urandom_range(1, NC-1));
    tick();
    lock = 1'b0;
    load_v = 1'b0;
    checks++;
    if ({locked, cfg_v, busy} !== 3'b110 || cfg !== pack_model()) begin
      errors++;
      $display("FAIL lock_beats_load: locked/cfg_v/busy got %b expected 110", {locked, cfg_v, busy});
    end
    load_v = 1'b1;
    tick();
    load_v = 1'b0;
    do_write(int'($urandom_range(0, NF-1)), FW'($urandom), 1'b1);
    ms = ms;
    load_v = 1'b1;
    cfg_sel = 4'd0;
    tick();
    load_v = 1'b0;
    tick();
    checks++;
    if ({locked, cfg_v, busy, w_ready, err} !== 5'b11000 || cfg !== pack_model()) begin
      errors++;
      $display("FAIL locked_ignores: flags %b cfg %h expected 11000 cfg %h", {locked, cfg_v, busy, w_ready, err}, cfg, pack_model());
    end
  endtask

  task automatic test_bad_sel();
    int sels [3];
    sels[0] = 0;
    sels[1] = NC;
    sels[2] = int'($urandom_range(NC + 1, 15));
    for (int i = 0; i < 3; i++) begin
      reset_pulse();
      load_v = 1'b1;
      cfg_sel = 4'(sels[i]);
      tick();
      load_v = 1'b0;
      cfg_sel = '0;
      tick();
      checks++;
      if ({err, busy, w_ready, cfg_v} !== 4'b1000) begin
        errors++;
        $display("FAIL bad_sel_%0d: err/busy/w_ready/cfg_v got %b expected 1000", sels[i], {err, busy, w_ready, cfg_v});
      end
    end
    do_load(int'($urandom_range(1, NC-1)), 1'b1, "load_after_bad_sel");
  endtask

  task automatic test_bad_write();
    do_write(NF, FW'($urandom), 1'b0);
    checks++;
    if (err !== 1'b1 || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_write_16: err/w_ready got %b%b expected 11", err, w_ready);
    end
    check_shadow("bad_write_16");
    do_write(int'($urandom_range(NF + 1, 31)), FW'($urandom), 1'b0);
    check_shadow("bad_write_hi");
    do_write(int'($urandom_range(0, NF-1)), FW'($urandom), 1'b0);
    check_shadow("good_write_after_bad");
  endtask

  task automatic test_reset_mid_load();
    reset_pulse();
    do_load(int'($urandom_range(1, NC-1)), 1'b1, "pre_reset_load");
    commit_and_check("pre_reset_commit");
    load_v = 1'b1;
    cfg_sel = 4'($urandom_range(1, NC-1));
    tick();
    load_v = 1'b0;
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    clear_model();
    checks++;
    if ({cfg_v, w_ready, busy, locked, err} !== 5'b0 || cfg !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: flags %b cfg %h expected 00000 and 0", {cfg_v, w_ready, busy, locked, err}, cfg);
    end
    check_shadow("reset_mid_load");
    reset = 1'b0;
    tick();
    do_load(4, 1'b1, "load_sel4_after_reset");
  endtask

  task automatic test_back_to_back();
    int nwr;
    int a;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) do_load(int'($urandom_range(1, NC-1)), 1'b0, "b2b_load");
      nwr = int'($urandom_range(0, 4));
      for (int i = 0; i < nwr; i++) begin
        a = int'($urandom_range(0, 19));
        do_write(a, FW'($urandom), 1'b0);
        if (a >= NF) begin
          checks++;
          if (err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bad_addr_%0d: err got %b expected 1", a, err);
          end
        end
      end
      check_shadow("b2b_edits");
      commit_and_check("b2b_commit");
    end
  endtask

`ifdef BP_CFG_LOADER_PARITY_EN
  task automatic test_parity();
    reset_pulse();
    do_load(int'($urandom_range(1, NC-1)), 1'b1, "parity_load");
    dut.par_q[2] = ~dut.par_q[2];
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++;
    if ({err, cfg_v, w_ready} !== 3'b101) begin
      errors++;
      $display("FAIL parity_block: err/cfg_v/w_ready got %b expected 101", {err, cfg_v, w_ready});
    end
  endtask
`endif

  initial begin
    clear_model();
    test_reset();
    test_load_basic();
    test_edit_commit();
    test_reload_active();
    test_lock();
    test_bad_sel();
    test_bad_write();
    test_reset_mid_load();
    test_back_to_back();
`ifdef BP_CFG_LOADER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
